// File: rtl/lsu_defs.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_defs;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational helpers: alignment/fault check on the incoming request,
// zero-extended load extraction and sub-word store merge on cache data.
module lsu_align
    import lsu_defs::*;
(
    input  logic [1:0]  chk_size,
    input  logic [1:0]  chk_addr_lo,
    input  logic [1:0]  size,
    input  logic [15:0] store_data,
    input  logic [31:0] rdata,
    output logic        fault,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    // Natural alignment check; size 11 is always illegal.
    always_comb begin
        fault = 1'b0;
        case (chk_size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = chk_addr_lo[0];
            SZ_WORD: fault = (chk_addr_lo != 2'b00);
            default: fault = 1'b1;
        endcase
    end

    // Cache returns the addressed byte in lane 0, so extraction is a mask.
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {24'b0, rdata[7:0]};
            SZ_HALF: load_data = {16'b0, rdata[15:0]};
            default: load_data = rdata;
        endcase
    end

    // Replace the low lane(s) of the fetched word with the store data.
    always_comb begin
        merged = {rdata[31:8], store_data[7:0]};
        if (size == SZ_HALF) begin
            merged = {rdata[31:16], store_data[15:0]};
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request capture, alignment faults, loads with zero
// extension, and read-modify-write for byte/half stores into a word cache.
module lsu
    import lsu_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    input  logic [3:0]  req_rd_i,
    output logic        wb_valid_o,
    output logic [3:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        fault_o,
    output logic [31:0] dc_address_o,
    output logic [31:0] dc_data_o,
    output logic        dc_we_o,
    input  logic [31:0] dc_data_i,
    input  logic        dc_stall_i
);

    lsu_state_t  state, state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [3:0]  rd_q;
    logic        ready_en;
    logic        wb_valid_q;
    logic [3:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        fault_q;

    logic        accept;
    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] merged;

    lsu_align u_align (
        .chk_size    (req_size_i),
        .chk_addr_lo (req_addr_i[1:0]),
        .size        (size_q),
        .store_data  (data_q[15:0]),
        .rdata       (dc_data_i),
        .fault       (req_fault),
        .load_data   (load_data),
        .merged      (merged)
    );

    assign req_ready_o  = (state == ST_IDLE) && ready_en;
    assign accept       = req_valid_i && req_ready_o;
    assign dc_address_o = addr_q;
    assign dc_data_o    = data_q;
    assign dc_we_o      = ((state == ST_STORE) || (state == ST_RMW_WR)) && rst_i;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign fault_o      = fault_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; every non-idle state waits out cache stalls.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (accept && !req_fault) begin
                    if (!req_we_i) begin
                        state_d = ST_LOAD;
                    end else if (req_size_i == SZ_WORD) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD, ST_STORE, ST_RMW_WR: begin
                if (!dc_stall_i) state_d = ST_IDLE;
            end
            ST_RMW_RD: begin
                if (!dc_stall_i) state_d = ST_RMW_WR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture, merged-word capture and result/fault pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            addr_q     <= '0;
            data_q     <= '0;
            size_q     <= '0;
            rd_q       <= '0;
            ready_en   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            wb_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            if (accept) begin
                addr_q  <= req_addr_i;
                data_q  <= req_data_i;
                size_q  <= req_size_i;
                rd_q    <= req_rd_i;
                fault_q <= req_fault;
            end
            if ((state == ST_LOAD) && !dc_stall_i) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_data_q  <= load_data;
            end
            if ((state == ST_RMW_RD) && !dc_stall_i) begin
                data_q <= merged;
            end
        end
    end

endmodule
